special_mult_seg_scan: RTL and testbench
========================================

// Module: special_mult_seg_scan
// PURPOSE
//  Registered, parametrised special multiplier driving a multiplexed multi-digit
//  common-anode 7-segment display. Each accepted input value is mapped by the
//  piecewise rule below. The result is held in a register and shown as hex
//  digits, one digit at a time, by a timed scan. Sits between board switches
//  (or an upstream block) and the 7-segment pins.
// PARAMETERS
//  IN_W       4   width of num input
//  NUM_DIGITS 2   number of display digits; result width RES_W = 4*NUM_DIGITS
//  LOW_MAX    2   num in [0..LOW_MAX]          -> res = num
//  MID_MAX    5   num in [LOW_MAX+1..MID_MAX]  -> res = (num+1)*2
//  HIGH_MAX   7   num in [MID_MAX+1..HIGH_MAX] -> res = (num-1)*2
//  SCAN_DIV   4   clk cycles each digit stays selected (>=1)
//  BLANK_LZ   1   1: blank leading-zero digits; 0: show all digits
// PORTS
//  clk        in   1           system clock, rising edge
//  rst_n      in   1           asynchronous reset, active-low
//  in_valid   in   1           num is sampled on this cycle
//  num        in   IN_W        operand
//  res        out  RES_W       registered mapped result
//  out_valid  out  1           1-cycle pulse: res updated
//  an         out  NUM_DIGITS  digit enables, active-low, one-hot-low
//  seg        out  7           segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (async, rst_n=0): res=0, out_valid=0, scan_cnt=0, dig_idx=0,
//   an=~1 (digit0 on), seg=7'b1000000 ("0"). All outputs hold these values
//   until the first clk edge after rst_n rises.
//  Mapping: num > HIGH_MAX -> res=0. Compute at width RES_W+1 (IN_W+2 if
//   larger), then truncate to RES_W; no saturation. Requires
//   LOW_MAX < MID_MAX < HIGH_MAX.
//  Latency: in_valid=1 at edge k -> res and out_valid=1 valid after edge k.
//   out_valid drops the next cycle unless in_valid is still 1. Back-to-back
//   in_valid is accepted every cycle. in_valid=0 holds res.
//  Scan: scan_cnt counts 0..SCAN_DIV-1 and wraps. On wrap, dig_idx increments
//   modulo NUM_DIGITS (NUM_DIGITS-1 -> 0). SCAN_DIV=1 advances every cycle.
//  an/seg are registered. They reflect the dig_idx and res values from the
//   previous cycle, so there is 1 cycle of lag after any change.
//   an[dig_idx]=0, all others=1.
//  seg encodes nibble res[4*dig_idx+3 : 4*dig_idx], active-low gfedcba:
//   0 1000000  1 1111001  2 0100100  3 0110000  4 0011001  5 0010010
//   6 0000010  7 1111000  8 0000000  9 0010000  A 0001000  b 0000011
//   C 1000110  d 0100001  E 0000110  F 0001110
//  Blanking (BLANK_LZ=1): a digit whose index is above the highest nonzero
//   nibble shows seg=7'b1111111; its an is still driven. Digit 0 is never
//   blanked, so res=0 shows "0".
//  A new res mid-scan takes effect on the current digit without restarting
//   the scan.
//  Reset asserted mid-operation: all state returns to reset values
//   immediately; the in-flight in_valid is discarded.
// TESTING
//  1 Reset: hold rst_n=0, toggle clk -> res=0, out_valid=0, an=2'b10,
//    seg=1000000. Release rst_n -> scan starts at digit0.
//  2 Mapping sweep (defaults): num=0..15, one in_valid each -> res =
//    0,1,2,8,10,12,10,12, then 0 for num=8..15. out_valid pulses 1 cycle after
//    each input.
//  3 Display: num=5 -> res=8'h0C. While digit0 is selected, seg=1000110 (C).
//    While digit1 is selected, seg=1111111 (blanked). With BLANK_LZ=0,
//    digit1 shows seg=1000000.
//  4 Scan timing (SCAN_DIV=4, NUM_DIGITS=2): an=10 for 4 cycles, then 01 for
//    4 cycles, then back to 10. Rerun with NUM_DIGITS=3, SCAN_DIV=1 -> an
//    rotates 110 -> 101 -> 011 every cycle.
//  5 Back-to-back: in_valid=1 for 3 cycles with num=3,4,6 -> res=8,10,10 on
//    consecutive edges; out_valid stays high for 3 cycles.
//  6 Reset mid-scan: num=7 (res=12), pulse rst_n low during digit1 -> res=0,
//    an=10, seg=1000000 asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/special_mult_seg_scan.sv
// Piecewise special multiplier with a registered result, shown as hex digits
// on a time-multiplexed common-anode 7-segment display (active-low an/seg).
module special_mult_seg_scan #(
  parameter int IN_W       = 4,
  parameter int NUM_DIGITS = 2,
  parameter int LOW_MAX    = 2,
  parameter int MID_MAX    = 5,
  parameter int HIGH_MAX   = 7,
  parameter int SCAN_DIV   = 4,
  parameter int BLANK_LZ   = 1,
  localparam int RES_W     = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       num,
  output logic [RES_W-1:0]      res,
  output logic                  out_valid,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg
);

  localparam int CW = (RES_W + 1 > IN_W + 2) ? RES_W + 1 : IN_W + 2;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [RES_W-1:0]      res_q, res_d;
  logic                  out_valid_q, out_valid_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [DW-1:0]         dig_idx_q, dig_idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic [CW-1:0] num_x;
  logic [DW-1:0] top_idx;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Mapping is evaluated at CW bits so (num+1)*2 cannot overflow before truncation.
  always_comb begin
    num_x       = CW'(num);
    res_d       = res_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      if (num_x <= CW'(LOW_MAX))
        res_d = RES_W'(num_x);
      else if (num_x <= CW'(MID_MAX))
        res_d = RES_W'((num_x + CW'(1)) << 1);
      else if (num_x <= CW'(HIGH_MAX))
        res_d = RES_W'((num_x - CW'(1)) << 1);
      else
        res_d = '0;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      if (dig_idx_q == DW'(NUM_DIGITS - 1))
        dig_idx_d = '0;
      else
        dig_idx_d = dig_idx_q + DW'(1);
    end
  end

  // Display uses the current (pre-edge) dig_idx/res, giving one cycle of lag.
  always_comb begin
    top_idx = '0;
    nib     = 4'h0;
    an_d    = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (res_q[4*i +: 4] != 4'h0) top_idx = DW'(i);
      if (DW'(i) == dig_idx_q) begin
        nib     = res_q[4*i +: 4];
        an_d[i] = 1'b0;
      end
    end
    blank = (BLANK_LZ != 0) && (dig_idx_q > top_idx);
    seg_d = blank ? 7'b1111111 : hex7(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      scan_cnt_q  <= '0;
      dig_idx_q   <= '0;
      an_q        <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      seg_q       <= 7'b1000000;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign res       = res_q;
  assign out_valid = out_valid_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_special_mult_seg_scan.sv
// Self-checking bench: two configurations driven in parallel, checked against
// an arithmetic model every cycle plus hand-computed literal expectations.
module tb_special_mult_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  num = 4'h0;

  logic [7:0]  res_a;
  logic        ov_a;
  logic [1:0]  an_a;
  logic [6:0]  seg_a;
  logic [11:0] res_b;
  logic        ov_b;
  logic [2:0]  an_b;
  logic [6:0]  seg_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  special_mult_seg_scan dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num),
    .res(res_a), .out_valid(ov_a), .an(an_a), .seg(seg_a)
  );

  special_mult_seg_scan #(.NUM_DIGITS(3), .SCAN_DIV(1), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num),
    .res(res_b), .out_valid(ov_b), .an(an_b), .seg(seg_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int        ND [2] = '{2, 3};
  int        SD [2] = '{4, 1};
  int        BL [2] = '{1, 0};
  int        RW [2] = '{8, 12};
  logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int         m_res [2];
  int         m_an  [2];
  logic [6:0] m_seg [2];
  int         m_ov;
  int         m_edges;

  function automatic int mapf(input int n, input int rw);
    int r;
    if (n <= 2)      r = n;
    else if (n <= 5) r = (n + 1) * 2;
    else if (n <= 7) r = (n - 1) * 2;
    else             r = 0;
    return r % (1 << rw);
  endfunction

  function automatic logic [6:0] disp(input int r, input int idx, input int bl, input int nd);
    int h = 0;
    for (int i = 0; i < nd; i++)
      if (((r >> (4 * i)) & 15) != 0) h = i;
    if (bl != 0 && idx > h) return 7'h7F;
    return SEGTAB[(r >> (4 * idx)) & 15];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_res[k] = 0;
        m_an[k]  = ((1 << ND[k]) - 1) & ~1;
        m_seg[k] = 7'h40;
      end else begin
        int idx;
        idx      = (m_edges / SD[k]) % ND[k];
        m_an[k]  = ((1 << ND[k]) - 1) ^ (1 << idx);
        m_seg[k] = disp(m_res[k], idx, BL[k], ND[k]);
        if (in_valid) m_res[k] = mapf(int'(num), RW[k]);
      end
    end
    m_ov    = rst_n ? int'(in_valid) : 0;
    m_edges = rst_n ? m_edges + 1 : 0;
  end

  always @(negedge clk) begin
    chk("model_res_a", 32'(res_a), 32'(m_res[0]));
    chk("model_ov_a",  32'(ov_a),  32'(m_ov));
    chk("model_an_a",  32'(an_a),  32'(m_an[0]));
    chk("model_seg_a", 32'(seg_a), 32'(m_seg[0]));
    chk("model_res_b", 32'(res_b), 32'(m_res[1]));
    chk("model_ov_b",  32'(ov_b),  32'(m_ov));
    chk("model_an_b",  32'(an_b),  32'(m_an[1]));
    chk("model_seg_b", 32'(seg_b), 32'(m_seg[1]));
  end

  // Waits (bounded) at negedges until the chosen DUT selects the wanted digit.
  task automatic wait_an(input int which, input logic [2:0] want, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (which == 0) ok = (an_a == want[1:0]);
      else            ok = (an_b == want);
    end
    if (!ok) chk("wait_an_timeout", 32'(0), 32'(1));
  endtask

  // ---------------- directed stimulus ----------------
  int         sweep_exp [16] = '{0, 1, 2, 8, 10, 12, 10, 12, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [1:0] scan_a    [9]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
  logic [2:0] scan_b    [4]  = '{3'b110, 3'b101, 3'b011, 3'b110};

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res",   32'(res_a), 32'h0);
    chk("rst_ov",    32'(ov_a),  32'h0);
    chk("rst_an",    32'(an_a),  32'b10);
    chk("rst_seg",   32'(seg_a), 32'b1000000);
    chk("rst_an_b",  32'(an_b),  32'b110);
    chk("rst_seg_b", 32'(seg_b), 32'b1000000);
    @(negedge clk) rst_n = 1'b1;

    for (int n = 0; n < 9; n++) begin
      @(posedge clk); #1;
      chk("scan_an_a", 32'(an_a), 32'(scan_a[n]));
      if (n < 4) chk("scan_an_b", 32'(an_b), 32'(scan_b[n]));
    end

    for (int v = 0; v < 16; v++) begin
      @(negedge clk); in_valid = 1'b1; num = 4'(v);
      @(posedge clk); #1;
      chk("sweep_res",   32'(res_a), 32'(sweep_exp[v]));
      chk("sweep_res_b", 32'(res_b), 32'(sweep_exp[v]));
      chk("sweep_ov",    32'(ov_a),  32'h1);
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      chk("sweep_ov_drop", 32'(ov_a), 32'h0);
      chk("sweep_hold",    32'(res_a), 32'(sweep_exp[v]));
    end

    @(negedge clk); in_valid = 1'b1; num = 4'd3;
    @(posedge clk); #1; chk("b2b_res0", 32'(res_a), 32'd8);  chk("b2b_ov0", 32'(ov_a), 32'h1);
    @(negedge clk); num = 4'd4;
    @(posedge clk); #1; chk("b2b_res1", 32'(res_a), 32'd10); chk("b2b_ov1", 32'(ov_a), 32'h1);
    @(negedge clk); num = 4'd6;
    @(posedge clk); #1; chk("b2b_res2", 32'(res_a), 32'd10); chk("b2b_ov2", 32'(ov_a), 32'h1);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1; chk("b2b_ov_end", 32'(ov_a), 32'h0);

    @(negedge clk); in_valid = 1'b1; num = 4'd5;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("disp_res", 32'(res_a), 32'h0C);
    wait_an(0, 3'b010, ok); if (ok) chk("disp_d0_C",     32'(seg_a), 32'b1000110);
    wait_an(0, 3'b001, ok); if (ok) chk("disp_d1_blank", 32'(seg_a), 32'b1111111);
    wait_an(1, 3'b101, ok); if (ok) chk("disp_b_d1_0",   32'(seg_b), 32'b1000000);
    wait_an(1, 3'b110, ok); if (ok) chk("disp_b_d0_C",   32'(seg_b), 32'b1000110);

    @(negedge clk); in_valid = 1'b1; num = 4'd7;
    @(negedge clk); in_valid = 1'b0;
    chk("pre_rst_res", 32'(res_a), 32'h0C);
    wait_an(0, 3'b001, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res", 32'(res_a), 32'h0);
    chk("arst_an",  32'(an_a),  32'b10);
    chk("arst_seg", 32'(seg_a), 32'b1000000);
    chk("arst_an_b", 32'(an_b), 32'b110);
    in_valid = 1'b1; num = 4'd4;
    @(posedge clk); #1;
    chk("arst_discard", 32'(res_a), 32'h0);
    chk("arst_ov",      32'(ov_a),  32'h0);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_an", 32'(an_a), 32'b10);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

endmodule
